// File: rtl/nn_node_mac_if.sv
// Control, input-stream and result handshake bundle for one nn_node_mac instance.
interface nn_node_mac_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = 7
);
    logic              start;
    logic [DATA_W-1:0] bias;
    logic [1:0]        act_mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_val;
    logic [DATA_W-1:0] coef;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  node_out;
    logic [CNT_W-1:0]  cnt_val;
    logic              busy;

    modport master (
        output start, bias, act_mode, in_valid, in_val, coef, out_ready,
        input  in_ready, out_valid, node_out, cnt_val, busy
    );

    modport slave (
        input  start, bias, act_mode, in_valid, in_val, coef, out_ready,
        output in_ready, out_valid, node_out, cnt_val, busy
    );
endinterface

// File: rtl/nn_node_mac.sv
// Streaming NN node: accumulates NUM_IN signed Q-format products onto a bias,
// then applies the latched activation and saturates to OUT_W.
module nn_node_mac #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int NUM_IN = 64,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 16,
    parameter int CNT_W  = $clog2(NUM_IN + 1)
) (
    input  logic         clk,
    input  logic         n_rst,
    nn_node_mac_if.slave io
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_ACT   = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;
    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    logic [1:0]              state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              mode_q, mode_d;
    logic [OUT_W-1:0]        out_q, out_d;
    logic                    ovld_q, ovld_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext, bias_ext, r, y;
    logic                     xfer, last;

    assign prod     = $signed(io.in_val) * $signed(io.coef);
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){io.bias[DATA_W-1]}}, io.bias} <<< FRAC_W;
    assign r        = acc_q >>> FRAC_W;
    assign xfer     = (state_q == S_ACCUM) && io.in_valid;
    assign last     = (cnt_q == CNT_W'(NUM_IN - 1));

    // Code 11 falls through to identity.
    always_comb begin
        y = r;
        case (mode_q)
            2'b01:   y = r[ACC_W-1] ? '0 : r;
            2'b10:   y = (!r[ACC_W-1] && (r != '0)) ? ACC_W'(1) : '0;
            default: y = r;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        out_d   = out_q;
        ovld_d  = ovld_q;
        case (state_q)
            S_IDLE: begin
                if (io.start) begin
                    acc_d   = bias_ext;
                    cnt_d   = '0;
                    mode_d  = io.act_mode;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (xfer) begin
                    acc_d = acc_q + prod_ext;
                    cnt_d = cnt_q + 1'b1;
                    if (last) state_d = S_ACT;
                end
            end
            S_ACT: begin
                if (y > SAT_MAX)      out_d = SAT_MAX[OUT_W-1:0];
                else if (y < SAT_MIN) out_d = SAT_MIN[OUT_W-1:0];
                else                  out_d = y[OUT_W-1:0];
                ovld_d  = 1'b1;
                state_d = S_OUT;
            end
            default: begin
                if (io.out_ready) begin
                    ovld_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
            out_q   <= '0;
            ovld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            out_q   <= out_d;
            ovld_q  <= ovld_d;
        end
    end

    assign io.in_ready  = (state_q == S_ACCUM);
    assign io.out_valid = ovld_q;
    assign io.node_out  = out_q;
    assign io.cnt_val   = cnt_q;
    assign io.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_nn_node_mac.sv
// Scoreboard bench: a 4-input node for protocol/activation cases and a 64-input node for saturation.
module tb_nn_node_mac;
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    nn_node_mac_if #(.DATA_W(16), .OUT_W(16), .CNT_W(3)) ifa ();
    nn_node_mac_if #(.DATA_W(16), .OUT_W(16), .CNT_W(7)) ifb ();

    nn_node_mac #(.NUM_IN(4), .CNT_W(3)) u_a (.clk(clk), .n_rst(n_rst), .io(ifa));
    nn_node_mac #(.NUM_IN(64), .CNT_W(7)) u_b (.clk(clk), .n_rst(n_rst), .io(ifb));

    int n_tests = 0;
    int n_fail  = 0;
    int qa[$];
    int qb[$];

    function automatic void chk(string nm, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Reference: exact integer dot product plus scaled bias, floor-shift, activation, clamp.
    function automatic int model(int bias, int mode, int v[$], int c[$]);
        longint acc, r, y;
        acc = longint'(bias) * 256;
        foreach (v[i]) acc += longint'(v[i]) * longint'(c[i]);
        r = acc >>> 8;
        case (mode)
            1:       y = (r < 0) ? 0 : r;
            2:       y = (r > 0) ? 1 : 0;
            default: y = r;
        endcase
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        return int'(y);
    endfunction

    function automatic int rnd16();
        logic [15:0] t;
        t = 16'($urandom);
        return int'($signed(t));
    endfunction

    always @(negedge clk) begin
        if (n_rst && ifa.out_valid && ifa.out_ready) begin
            if (qa.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_a_extra: node_out %0d with no expected result", $signed(ifa.node_out));
            end else chk("sb_a_node_out", int'($signed(ifa.node_out)), qa.pop_front());
        end
    end

    always @(negedge clk) begin
        if (n_rst && ifb.out_valid && ifb.out_ready) begin
            if (qb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_b_extra: node_out %0d with no expected result", $signed(ifb.node_out));
            end else chk("sb_b_node_out", int'($signed(ifb.node_out)), qb.pop_front());
        end
    end

    task automatic wait_idle_a();
        int k = 0;
        while (ifa.busy !== 1'b0 && k < 300) begin @(posedge clk); #1; k++; end
        chk("a_idle_timeout", int'(ifa.busy), 0);
    endtask

    task automatic wait_idle_b();
        int k = 0;
        while (ifb.busy !== 1'b0 && k < 300) begin @(posedge clk); #1; k++; end
        chk("b_idle_timeout", int'(ifb.busy), 0);
    endtask

    task automatic start_a(input int bias, input int mode, input int exp);
        chk("a_idle_in_ready", int'(ifa.in_ready), 0);
        ifa.start = 1'b1; ifa.bias = 16'(bias); ifa.act_mode = 2'(mode);
        @(posedge clk); #1;
        ifa.start = 1'b0; ifa.bias = 16'($urandom); ifa.act_mode = 2'($urandom);
        qa.push_back(exp);
        chk("a_cnt_after_start", int'(ifa.cnt_val), 0);
        chk("a_busy_after_start", int'(ifa.busy), 1);
    endtask

    task automatic op_a(input int bias, input int mode, input int v[$], input int c[$],
                        input bit gaps, input int hold);
        int exp;
        exp = model(bias, mode, v, c);
        ifa.out_ready = (hold == 0);
        start_a(bias, mode, exp);
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                ifa.in_valid = 1'b0; ifa.in_val = 16'($urandom);
                @(posedge clk); #1;
                chk("a_cnt_stall", int'(ifa.cnt_val), i);
            end
            ifa.in_valid = 1'b1; ifa.in_val = 16'(v[i]); ifa.coef = 16'(c[i]);
            @(posedge clk); #1;
            chk("a_cnt_xfer", int'(ifa.cnt_val), i + 1);
        end
        ifa.in_valid = 1'b0;
        chk("a_act_in_ready", int'(ifa.in_ready), 0);
        chk("a_act_out_valid", int'(ifa.out_valid), 0);
        @(posedge clk); #1;
        chk("a_out_valid_latency", int'(ifa.out_valid), 1);
        for (int k = 0; k < hold; k++) begin
            chk("a_hold_valid", int'(ifa.out_valid), 1);
            chk("a_hold_node_out", int'($signed(ifa.node_out)), exp);
            ifa.start = 1'b1; ifa.in_valid = 1'b1; ifa.bias = 16'($urandom);
            @(posedge clk); #1;
            ifa.start = 1'b0; ifa.in_valid = 1'b0;
        end
        if (hold > 0) begin
            chk("a_hold_cnt", int'(ifa.cnt_val), 4);
            ifa.out_ready = 1'b1;
            @(posedge clk); #1;
            chk("a_release_valid", int'(ifa.out_valid), 0);
            chk("a_release_busy", int'(ifa.busy), 0);
        end
        wait_idle_a();
    endtask

    task automatic op_b(input int bias, input int mode, input int v[$], input int c[$]);
        ifb.out_ready = 1'b1;
        ifb.start = 1'b1; ifb.bias = 16'(bias); ifb.act_mode = 2'(mode);
        @(posedge clk); #1;
        ifb.start = 1'b0;
        qb.push_back(model(bias, mode, v, c));
        for (int i = 0; i < 64; i++) begin
            ifb.in_valid = 1'b1; ifb.in_val = 16'(v[i]); ifb.coef = 16'(c[i]);
            @(posedge clk); #1;
        end
        ifb.in_valid = 1'b0;
        chk("b_cnt_final", int'(ifb.cnt_val), 64);
        wait_idle_b();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v1[$], cp[$], cn[$], z[$], rv[$], rc[$], bm[$], bp[$], bn[$];
        int e;
        v1 = '{256, 256, 256, 256};
        cp = '{512, 512, 512, 512};
        cn = '{-512, -512, -512, -512};
        z  = '{0, 0, 0, 0};
        for (int i = 0; i < 64; i++) begin bm.push_back(32767); bp.push_back(32767); bn.push_back(-32767); end

        ifa.start = 0; ifa.bias = 0; ifa.act_mode = 0; ifa.in_valid = 0;
        ifa.in_val = 0; ifa.coef = 0; ifa.out_ready = 1;
        ifb.start = 0; ifb.bias = 0; ifb.act_mode = 0; ifb.in_valid = 0;
        ifb.in_val = 0; ifb.coef = 0; ifb.out_ready = 1;

        #1;
        chk("rst_in_ready", int'(ifa.in_ready), 0);
        chk("rst_busy", int'(ifa.busy), 0);
        chk("rst_cnt", int'(ifa.cnt_val), 0);
        chk("rst_node_out", int'(ifa.node_out), 0);
        chk("rst_out_valid", int'(ifa.out_valid), 0);
        chk("rst_b_busy", int'(ifb.busy), 0);
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;

        op_a(0, 0, v1, cp, 0, 0);
        chk("model_identity_2048", model(0, 0, v1, cp), 2048);

        // Asynchronous reset after two of four pairs.
        e = model(0, 0, v1, cp);
        start_a(0, 0, e);
        for (int i = 0; i < 2; i++) begin
            ifa.in_valid = 1'b1; ifa.in_val = 16'(v1[i]); ifa.coef = 16'(cp[i]);
            @(posedge clk); #1;
        end
        n_rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", int'(ifa.in_ready), 0);
        chk("mid_rst_busy", int'(ifa.busy), 0);
        chk("mid_rst_cnt", int'(ifa.cnt_val), 0);
        chk("mid_rst_node_out", int'(ifa.node_out), 0);
        chk("mid_rst_out_valid", int'(ifa.out_valid), 0);
        qa.delete();
        ifa.in_valid = 1'b0;
        @(negedge clk); n_rst = 1'b1;
        @(posedge clk); #1;
        op_a(0, 0, v1, cp, 0, 0);

        op_a(0, 0, v1, cn, 0, 0);
        op_a(0, 1, v1, cn, 0, 0);
        op_a(1, 2, z, z, 0, 0);
        op_a(0, 2, z, z, 0, 0);
        op_a(-256, 0, z, z, 0, 0);
        op_a(0, 3, v1, cn, 0, 0);
        op_a(0, 0, v1, cp, 1, 5);

        for (int n = 0; n < 25; n++) begin
            rv.delete(); rc.delete();
            for (int i = 0; i < 4; i++) begin
                if (n < 12) begin
                    rv.push_back($urandom_range(0, 1023) - 512);
                    rc.push_back($urandom_range(0, 1023) - 512);
                end else begin
                    rv.push_back(rnd16()); rc.push_back(rnd16());
                end
            end
            op_a(rnd16(), $urandom_range(0, 3), rv, rc, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end

        op_b(0, 0, bm, bp);
        op_b(0, 0, bm, bn);
        op_b(0, 1, bm, bn);
        for (int n = 0; n < 2; n++) begin
            rv.delete(); rc.delete();
            for (int i = 0; i < 64; i++) begin
                rv.push_back($urandom_range(0, 511) - 256);
                rc.push_back($urandom_range(0, 511) - 256);
            end
            op_b(rnd16(), n, rv, rc);
        end

        repeat (2) @(posedge clk);
        #1;
        chk("sb_a_drained", qa.size(), 0);
        chk("sb_b_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/nn_node_mac.md
Name: nn_node_mac

Overview:
Parametrised neural-network node: a sequential multiply-accumulate over NUM_IN signed fixed-point (input, coefficient) pairs.
- Pairs are streamed one per cycle under a valid/ready handshake, rather than presented as a full parallel array.
- Adds a bias, applies a run-time-selectable activation, and saturates the result to OUT_W.
- Sits between the layer input buffer and the next layer's input stream; one instance per node.

Parameters:
DATA_W, 16, width of in_val, coef and bias (signed two's complement, Q format with FRAC_W fraction bits)
FRAC_W, 8, fraction bits of in_val/coef/bias/node_out
NUM_IN, 64, pairs accumulated per operation (>=1)
ACC_W, 40, accumulator width; must be >= 2*DATA_W + clog2(NUM_IN) + 1
OUT_W, 16, node_out width (signed, Q with FRAC_W fraction bits)
CNT_W, clog2(NUM_IN+1), cnt_val width (7 at default)

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  reset; asynchronous, active-low
start  in  1  begin operation; sampled only in IDLE
bias  in  DATA_W  signed bias; latched on accepted start
act_mode  in  2  latched on accepted start: 00 identity, 01 ReLU, 10 step, 11 treated as identity
in_valid  in  1  in_val/coef pair valid
in_ready  out  1  node accepts pair this cycle
in_val  in  DATA_W  signed input sample
coef  in  DATA_W  signed weight
out_valid  out  1  node_out valid
out_ready  in  1  downstream accepts node_out
node_out  out  OUT_W  activated, saturated result
cnt_val  out  CNT_W  pairs accepted in current operation
busy  out  1  state != IDLE

Behaviour:
- Reset (n_rst=0, asynchronous, takes effect immediately, including mid-operation):
  - state IDLE; acc, cnt_val and node_out = 0; in_ready, out_valid and busy = 0.
  - Any partial accumulation is discarded.
- States: IDLE, ACCUM, ACT, OUT.
- IDLE:
  - in_ready = 0.
  - start = 1: acc <= sign_ext(bias) << FRAC_W; cnt_val <= 0; latch act_mode; go to ACCUM.
- ACCUM:
  - in_ready = 1.
  - Transfer = in_valid & in_ready: acc <= acc + sign_ext(in_val * coef), using the full 2*DATA_W signed product; cnt_val <= cnt_val + 1.
  - in_valid = 0 stalls; acc and cnt_val hold.
  - A transfer with cnt_val == NUM_IN-1 moves to ACT; in_ready is 0 from the following cycle.
- ACT (exactly one cycle):
  - r = acc >>> FRAC_W (arithmetic shift).
  - identity: y = r. ReLU: y = (r < 0) ? 0 : r. step: y = (r > 0) ? 1 : 0 (integer 1, strict inequality).
  - y is saturated to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - node_out <= y; out_valid <= 1; go to OUT.
  - Latency: out_valid is high on the second rising edge after the final transfer edge is counted as edge 0; i.e. visible one cycle after the final handshake cycle.
- OUT:
  - node_out and out_valid hold until out_valid & out_ready.
  - Then out_valid <= 0 and the state returns to IDLE.
  - A new start is accepted no earlier than the cycle after the return to IDLE.
- Accumulator: wraps modulo 2^ACC_W and never saturates (the ACC_W rule guarantees no wrap). Saturation is applied only at the output.
- cnt_val: holds NUM_IN through ACT/OUT/IDLE until the next accepted start.
- Ignored inputs:
  - start outside IDLE.
  - in_valid outside ACCUM.
  - out_ready while out_valid = 0.
  - bias/act_mode changes after the start is accepted.
- NUM_IN = 1: a single transfer goes straight to ACT.

Test Plan:
- Reset mid-ACCUM after 2 of 4 pairs (NUM_IN=4): drive n_rst=0 between edges -> immediately in_ready=0, busy=0, cnt_val=0, node_out=0, out_valid=0. Then a new start with the same data gives the clean result.
- Identity (NUM_IN=4, bias=0, in_val=256 (1.0), coef=512 (2.0), continuous valid) -> cnt_val 1..4; out_valid one cycle after 4th transfer; node_out=2048 (8.0).
- ReLU/identity sign (same as previous, coef=-512) -> identity node_out=-2048 (0xF800); ReLU node_out=0.
- Saturation (NUM_IN=64, in_val=coef=32767, identity) -> node_out=32767; with coef=-32767 -> node_out=-32768; ReLU of the negative case -> 0.
- Step and bias (NUM_IN=4, in_val=0, act_mode=10):
  - bias=1 -> node_out=1.
  - bias=0 -> node_out=0 (strict >).
  - bias=-256 with identity -> node_out=-256.
- Backpressure (identity case):
  - in_valid toggled every other cycle -> cnt_val increments only on transfers; node_out=2048.
  - out_ready held low 5 cycles -> node_out/out_valid stable; start pulses during OUT ignored.
  - out_ready=1 -> out_valid low next cycle, busy=0.
